local_mem_responder: RTL
========================

LOCAL_MEM_RESPONDER -- requirements
Module: local_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit words stored; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port addr  input  30: word address from the master.
REQ-005 SHALL have port en  input  1: access request, valid this cycle.
REQ-006 SHALL have port be  input  4: byte write enables; 4'b0000 with en=1 means read.
REQ-007 SHALL have port data_in  input  32: write data; byte i is bits [8i+7:8i].
REQ-008 SHALL have port data_out  output  32: read data.
REQ-009 SHALL have port init_done  output  1: high once zero-initialisation is complete.

Function
REQ-010 SHALL index storage with addr[log2(DEPTH)-1:0] only; upper address bits are ignored, so accesses wrap modulo DEPTH.
REQ-011 SHALL implement FSM states INIT and RUN; reset enters INIT with the init pointer at 0.
REQ-012 In INIT, SHALL write 32'h0 to the word at the init pointer on every edge and increment the pointer.
REQ-013 SHALL write word DEPTH-1 and move to RUN on the DEPTH-th edge after rst deasserts, so init_done is high exactly DEPTH cycles after reset release.
REQ-014 In INIT, SHALL ignore en, be and data_in, hold data_out at 32'h0, and hold init_done low.
REQ-015 In RUN, en=1 with be=0 SHALL load data_out with mem[addr] on the next edge: 1-cycle latency.
REQ-016 In RUN, en=1 with be!=0 SHALL update only the enabled bytes on the next edge.
REQ-017 A write SHALL also load data_out with the pre-write word (read-first semantics).
REQ-018 In RUN with en=0, SHALL leave memory unchanged and hold data_out.
REQ-019 Back-to-back accesses SHALL be accepted every cycle with no stall; a read immediately after a write to the same address SHALL return the newly written data.
REQ-020 In RUN, init_done SHALL stay high until the next reset.

Reset
REQ-021 rst=0 on an edge SHALL set state to INIT, init pointer to 0, data_out to 32'h0, init_done to 0, and any output pipeline register to 32'h0.
REQ-022 Reset asserted mid-operation, in either INIT or RUN, SHALL discard any in-flight access and restart the full zero-initialisation from word 0.

Configuration
REQ-023 Macro LOCAL_MEM_OUTPUT_REG_EN, when defined, SHALL add one output register stage, making read latency 2 cycles.
REQ-024 With LOCAL_MEM_OUTPUT_REG_EN defined, the extra stage SHALL load only when the delayed en is high; its reset value is 0.
REQ-025 Without LOCAL_MEM_OUTPUT_REG_EN, read latency SHALL be 1 cycle and no extra register SHALL exist.

Structure
REQ-026 Shared package local_mem_pkg SHALL hold: data width 32, address width 30, byte-enable width 4, and the FSM state enum {INIT, RUN}.
REQ-027 Sub-module local_mem_init_seq SHALL contain the INIT/RUN FSM and init pointer counter, providing the write address, write-enable and init_done.
REQ-028 Storage SHALL be a single array inferable as block RAM with per-byte write enables.

Verification (DEPTH=16, output register off unless noted)
REQ-029 Reset release -> init_done low for cycles 1-15 and high from cycle 16; en=1 reads during init return 0; every word reads 32'h0 after init_done.
REQ-030 Write addr=5, be=4'hF, data=32'hDEADBEEF; then read addr=5 -> data_out=32'hDEADBEEF one cycle after the read.
REQ-031 Write addr=3 be=4'hF data 32'h11223344, then be=4'b0101 data 32'hAABBCCDD -> read returns 32'h11BB33DD; the second write's data_out=32'h11223344.
REQ-032 Write addr=30'h12 data 32'h0000CAFE -> read addr=2 returns 32'h0000CAFE (wrap).
REQ-033 Fill words, assert rst for 1 cycle mid-run -> data_out=0, init_done drops, 16 cycles later all words read 0.
REQ-034 LOCAL_MEM_OUTPUT_REG_EN defined: write then read addr 7 -> data appears on data_out 2 cycles after the read, and holds while en=0.

Source files
------------

// File: rtl/local_mem_pkg.sv
// rtl/local_mem_pkg.sv - shared widths and FSM state type for the local memory responder
package local_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int BE_W   = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : local_mem_pkg

// File: rtl/local_mem_init_seq.sv
// rtl/local_mem_init_seq.sv - INIT/RUN sequencer that sweeps zero-writes across every word after reset
module local_mem_init_seq
    import local_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       init_we_o,
    output logic [$clog2(DEPTH)-1:0]   init_addr_o,
    output logic                       init_done_o
);

    localparam int AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The last word is written on the same edge that hands over to RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_we_o = 1'b0;
        case (state_q)
            INIT: begin
                init_we_o = 1'b1;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign init_addr_o = ptr_q;
    assign init_done_o = (state_q == RUN);

endmodule : local_mem_init_seq

// File: rtl/local_mem_responder.sv
// rtl/local_mem_responder.sv - zero-initialised byte-writable word memory, read-first; LOCAL_MEM_OUTPUT_REG_EN adds an output stage
module local_mem_responder
    import local_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              init_done
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic [AW-1:0]     init_addr;
    logic              init_we;
    logic              run;
    logic [AW-1:0]     wr_addr;
    logic [BE_W-1:0]   wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_q;
    logic              unused_addr_hi;

    assign idx            = addr[AW-1:0];
    assign unused_addr_hi = ^addr[ADDR_W-1:AW];

    local_mem_init_seq #(
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_done_o (run)
    );

    // One write port shared by the init sweep and master writes.
    always_comb begin
        wr_addr = idx;
        wr_be   = '0;
        wr_data = data_in;
        if (init_we) begin
            wr_addr = init_addr;
            wr_be   = '1;
            wr_data = '0;
        end else if (run && en) begin
            wr_be   = be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q <= '0;
        end else if (run && en) begin
            rd_q <= mem[idx];
        end
    end

`ifdef LOCAL_MEM_OUTPUT_REG_EN
    logic              en_d_q;
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_d_q <= 1'b0;
            out_q  <= '0;
        end else begin
            en_d_q <= run && en;
            if (en_d_q) begin
                out_q <= rd_q;
            end
        end
    end

    assign data_out = out_q;
`else
    assign data_out = rd_q;
`endif

    assign init_done = run;

endmodule : local_mem_responder
